// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, instruction classes,
// MIPS opcode/funct values, datapath select codes and PC target helpers.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_NOP,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_BGEZ,
        CLS_JR,
        CLS_J,
        CLS_JAL
    } instr_cls_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;

    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    localparam logic [2:0] ALU_ADDU   = 3'd0;
    localparam logic [2:0] ALU_SUBU   = 3'd1;
    localparam logic [2:0] ALU_OR     = 3'd2;

    localparam logic [1:0] RD_RT      = 2'b00;
    localparam logic [1:0] RD_RD      = 2'b01;
    localparam logic [1:0] RD_RA      = 2'b10;

    localparam logic [1:0] M2R_ALU    = 2'b00;
    localparam logic [1:0] M2R_DM     = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGN   = 2'b01;
    localparam logic [1:0] EXT_LUI    = 2'b10;

    function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] idx);
        return {pc_hi, idx, 2'b00};
    endfunction

    // pc_plus4 is the already-incremented PC, matching MIPS branch semantics.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4, input logic [15:0] imm16);
        logic signed [31:0] offset;
        offset = {{14{imm16[15]}}, imm16, 2'b00};
        return pc_plus4 + $unsigned(offset);
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Instruction and data memory req/ack ports of the multi-cycle sequencer.
interface mc_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies the IR word and derives the
// datapath select fields (reg_dst, mem_to_reg, alu_src, ext_op, alu_op, lb, sb).
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output instr_cls_t  cls,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  ext_op,
    output logic [2:0]  alu_op,
    output logic        lb,
    output logic        sb
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];

    always_comb begin
        cls        = CLS_ILLEGAL;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        alu_src    = 1'b0;
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADDU;
        lb         = 1'b0;
        sb         = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU: begin
                        cls     = CLS_ALU;
                        reg_dst = RD_RD;
                        alu_op  = ALU_ADDU;
                    end
                    FN_SUBU: begin
                        cls     = CLS_ALU;
                        reg_dst = RD_RD;
                        alu_op  = ALU_SUBU;
                    end
                    FN_JR: cls = CLS_JR;
                    // Only the canonical all-zero sll is supported (as nop).
                    FN_SLL: if (instr == 32'h0) cls = CLS_NOP;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                cls     = CLS_ALU;
                alu_src = 1'b1;
                ext_op  = EXT_ZERO;
                alu_op  = ALU_OR;
            end
            OP_LUI: begin
                cls     = CLS_ALU;
                alu_src = 1'b1;
                ext_op  = EXT_LUI;
                alu_op  = ALU_OR;
            end
            OP_LW, OP_LB: begin
                cls        = CLS_LOAD;
                alu_src    = 1'b1;
                ext_op     = EXT_SIGN;
                mem_to_reg = M2R_DM;
                lb         = (opcode == OP_LB);
            end
            OP_SW, OP_SB: begin
                cls     = CLS_STORE;
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                sb      = (opcode == OP_SB);
            end
            OP_BEQ: begin
                cls    = CLS_BEQ;
                ext_op = EXT_SIGN;
                alu_op = ALU_SUBU;
            end
            OP_REGIMM: begin
                if (rt == RT_BGEZ) begin
                    cls    = CLS_BGEZ;
                    ext_op = EXT_SIGN;
                end
            end
            OP_J: cls = CLS_J;
            OP_JAL: begin
                cls        = CLS_JAL;
                reg_dst    = RD_RA;
                mem_to_reg = M2R_PC;
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle core sequencer: owns PC, IR and the FETCH/DECODE/EXEC/MEM/WB FSM.
// Define ILLEGAL_TRAP_EN to halt on unknown instructions; otherwise they run as nop.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    mc_sequencer_if.master bus,
    input  logic          alu_zero,
    input  logic          alu_gez,
    input  logic [31:0]   jr_target,
    output logic [31:0]   instr,
    output logic [31:0]   pc,
    output logic          reg_wr,
    output logic [1:0]    reg_dst,
    output logic [1:0]    mem_to_reg,
    output logic          alu_src,
    output logic [1:0]    ext_op,
    output logic [2:0]    alu_op,
    output logic          lb,
    output logic          sb,
    output logic          bus_err,
    output logic [2:0]    state
);

    localparam int          CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TMAX  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t             state_q, state_next;
    logic [31:0]        pc_q, pc_next;
    logic [31:0]        instr_q, instr_next;
    logic               bus_err_q, bus_err_next;
    logic [CNT_W-1:0]   wait_q, wait_next;
    logic               timeout_hit;
    logic               imem_req_c, dmem_req_c, reg_wr_c, strobe_c;

    instr_cls_t cls;
    logic [1:0] d_reg_dst, d_mem_to_reg, d_ext_op;
    logic [2:0] d_alu_op;
    logic       d_alu_src, d_lb, d_sb;

    mc_decode u_decode (
        .instr      (instr_q),
        .cls        (cls),
        .reg_dst    (d_reg_dst),
        .mem_to_reg (d_mem_to_reg),
        .alu_src    (d_alu_src),
        .ext_op     (d_ext_op),
        .alu_op     (d_alu_op),
        .lb         (d_lb),
        .sb         (d_sb)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == CNT_W'(TMAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            bus_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_next;
            pc_q      <= pc_next;
            instr_q   <= instr_next;
            bus_err_q <= bus_err_next;
            wait_q    <= wait_next;
        end
    end

    // wait_next defaults to 0 so the counter restarts every time a request rises.
    always_comb begin
        state_next   = state_q;
        pc_next      = pc_q;
        instr_next   = instr_q;
        bus_err_next = bus_err_q;
        wait_next    = '0;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        reg_wr_c     = 1'b0;
        strobe_c     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    instr_next = bus.imem_rdata;
                    pc_next    = pc_q + 32'd4;
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    bus_err_next = 1'b1;
                    state_next   = ST_HALT;
                end else begin
                    wait_next = wait_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_J: begin
                        pc_next    = jump_target(pc_q[31:28], instr_q[25:0]);
                        state_next = ST_FETCH;
                    end
                    CLS_JAL: state_next = ST_WB;
`ifdef ILLEGAL_TRAP_EN
                    CLS_ILLEGAL: state_next = ST_HALT;
`else
                    CLS_ILLEGAL: state_next = ST_EXEC;
`endif
                    default: state_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                strobe_c = 1'b1;
                case (cls)
                    CLS_ALU: state_next = ST_WB;
                    CLS_LOAD, CLS_STORE: state_next = ST_MEM;
                    CLS_BEQ: begin
                        if (alu_zero) pc_next = branch_target(pc_q, instr_q[15:0]);
                        state_next = ST_FETCH;
                    end
                    CLS_BGEZ: begin
                        if (alu_gez) pc_next = branch_target(pc_q, instr_q[15:0]);
                        state_next = ST_FETCH;
                    end
                    CLS_JR: begin
                        pc_next    = jr_target;
                        state_next = ST_FETCH;
                    end
                    default: state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                strobe_c   = 1'b1;
                dmem_req_c = 1'b1;
                if (bus.dmem_ack) begin
                    state_next = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (timeout_hit) begin
                    bus_err_next = 1'b1;
                    state_next   = ST_HALT;
                end else begin
                    wait_next = wait_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                strobe_c = 1'b1;
                reg_wr_c = 1'b1;
                // jal links the already-incremented pc into $31 this cycle, then jumps.
                if (cls == CLS_JAL) pc_next = jump_target(pc_q[31:28], instr_q[25:0]);
                state_next = ST_FETCH;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
    end

    assign bus.imem_req  = imem_req_c & ~reset;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_c & ~reset;
    assign bus.dmem_we   = bus.dmem_req & (cls == CLS_STORE);

    assign instr      = instr_q;
    assign pc         = pc_q;
    assign bus_err    = bus_err_q;
    assign state      = state_q;
    assign reg_wr     = reg_wr_c & ~reset;
    assign reg_dst    = (strobe_c & ~reset) ? d_reg_dst    : RD_RT;
    assign mem_to_reg = (strobe_c & ~reset) ? d_mem_to_reg : M2R_ALU;
    assign alu_src    = strobe_c & ~reset & d_alu_src;
    assign ext_op     = (strobe_c & ~reset) ? d_ext_op     : EXT_ZERO;
    assign alu_op     = (strobe_c & ~reset) ? d_alu_op     : ALU_ADDU;
    assign lb         = strobe_c & ~reset & d_lb;
    assign sb         = strobe_c & ~reset & d_sb;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: a small instruction/data memory driver plus a
// scoreboard of expected fetch addresses, one task per scenario.
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_zero, alu_gez;
    logic [31:0] jr_target;
    logic [31:0] instr, pc;
    logic        reg_wr, alu_src, lb, sb, bus_err;
    logic [1:0]  reg_dst, mem_to_reg, ext_op;
    logic [2:0]  alu_op, state;

    always #5 clk = ~clk;

    mc_sequencer_if bus ();

    mc_sequencer #(.RESET_PC(32'h0000_3000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .alu_zero(alu_zero), .alu_gez(alu_gez), .jr_target(jr_target),
        .instr(instr), .pc(pc), .reg_wr(reg_wr), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .ext_op(ext_op),
        .alu_op(alu_op), .lb(lb), .sb(sb), .bus_err(bus_err), .state(state)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_addr[$];

    logic [31:0] r_faddr, r_pcwr;
    int          r_cycles, r_wr, r_wr_cycle, r_dreq;
    logic [1:0]  r_rdst, r_m2r, r_ext;
    logic [2:0]  r_aluop;
    logic        r_alusrc, r_we, r_lb, r_sb, r_stable;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays instruction memory (ack after iwait cycles) and data memory (ack after dwait
    // cycles) for one instruction, recording what the DUT presented along the way.
    task automatic run_instr(input logic [31:0] word, input int iwait, input int dwait, input bit spurious);
        int  w, dw;
        bit  fetched;
        w = 0; dw = 0; fetched = 0;
        r_faddr = bus.imem_addr; r_cycles = 0; r_wr = 0; r_wr_cycle = 0; r_dreq = 0;
        r_rdst = 2'b11; r_m2r = 2'b11; r_ext = 2'b11; r_aluop = 3'b111; r_pcwr = '0;
        r_alusrc = 1'b0; r_we = 1'b0; r_lb = 1'b0; r_sb = 1'b0; r_stable = 1'b1;
        for (int c = 0; c < 64; c++) begin
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            if (bus.dmem_req === 1'b1) r_dreq++;
            if (state == 3'd0 && !fetched) begin
                if (bus.imem_addr !== r_faddr || bus.imem_req !== 1'b1) r_stable = 1'b0;
                if (w >= iwait) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = word;
                    fetched = 1;
                end
                w++;
            end else if (state == 3'd3) begin
                r_we |= bus.dmem_we;
                r_sb |= sb;
                if (dw >= dwait) bus.dmem_ack = 1'b1;
                dw++;
            end else if (spurious) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = 32'hDEAD_BEEF;
                bus.dmem_ack = 1'b1;
            end
            if (reg_wr === 1'b1) begin
                r_wr++;
                r_wr_cycle = r_cycles + 1;
                r_rdst = reg_dst; r_m2r = mem_to_reg; r_ext = ext_op; r_aluop = alu_op;
                r_alusrc = alu_src; r_lb = lb; r_pcwr = pc;
            end
            r_cycles++;
            tick();
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            if (state == 3'd5 || (fetched && state == 3'd0)) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = '0;
        tick(); tick();
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
        vectors++; if (pc !== 32'h3000) begin miscompares++; $display("FAIL reset_pc: got %h want 00003000", pc); end
        vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", instr); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        vectors++; if ({bus.imem_req, bus.dmem_req, reg_wr, alu_src, lb, sb} !== 6'b0) begin
            miscompares++; $display("FAIL reset_strobes: got %b want 000000", {bus.imem_req, bus.dmem_req, reg_wr, alu_src, lb, sb}); end
        reset = 1'b0;
        #1;
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL reset_release_req: got %b want 1", bus.imem_req); end
        exp_addr.delete();
        exp_addr.push_back(32'h3000);
    endtask

    task automatic test_alu();
        logic [31:0] e;
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b001101, 5'd0, 5'd1, 16'h1234), 0, 0, 0);
        exp_addr.push_back(32'h3004);
        vectors++; if (r_faddr !== e) begin miscompares++; $display("FAIL ori_fetch_addr: got %h want %h", r_faddr, e); end
        vectors++; if (r_cycles !== 4) begin miscompares++; $display("FAIL ori_latency: got %0d want 4", r_cycles); end
        vectors++; if (r_wr !== 1 || r_wr_cycle !== 4) begin miscompares++; $display("FAIL ori_reg_wr: got %0d pulses at cycle %0d want 1 at 4", r_wr, r_wr_cycle); end
        vectors++; if ({r_rdst, r_m2r, r_alusrc, r_ext, r_aluop} !== {2'b00, 2'b00, 1'b1, 2'b00, 3'd2}) begin
            miscompares++; $display("FAIL ori_strobes: got %b want %b", {r_rdst, r_m2r, r_alusrc, r_ext, r_aluop}, {2'b00, 2'b00, 1'b1, 2'b00, 3'd2}); end
        vectors++; if (pc !== 32'h3004) begin miscompares++; $display("FAIL ori_pc: got %h want 00003004", pc); end
        e = exp_addr.pop_front();
        run_instr(enc_r(5'd1, 5'd2, 5'd3, 6'b100001), 2, 0, 0);
        exp_addr.push_back(32'h3008);
        vectors++; if (r_faddr !== e || r_stable !== 1'b1) begin miscompares++; $display("FAIL addu_fetch_addr: got %h stable %b want %h stable 1", r_faddr, r_stable, e); end
        vectors++; if (r_cycles !== 6) begin miscompares++; $display("FAIL addu_wait_latency: got %0d want 6", r_cycles); end
        vectors++; if ({r_rdst, r_alusrc, r_aluop} !== {2'b01, 1'b0, 3'd0}) begin
            miscompares++; $display("FAIL addu_strobes: got %b want %b", {r_rdst, r_alusrc, r_aluop}, {2'b01, 1'b0, 3'd0}); end
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b001111, 5'd0, 5'd4, 16'hABCD), 0, 0, 0);
        exp_addr.push_back(32'h300C);
        vectors++; if (r_faddr !== e) begin miscompares++; $display("FAIL lui_fetch_addr: got %h want %h", r_faddr, e); end
        vectors++; if (r_ext !== 2'b10 || r_wr !== 1) begin miscompares++; $display("FAIL lui_ext_op: got ext %b wr %0d want 10 and 1", r_ext, r_wr); end
    endtask

    task automatic test_load();
        logic [31:0] e;
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b100011, 5'd1, 5'd5, 16'h0010), 0, 3, 0);
        exp_addr.push_back(32'h3010);
        vectors++; if (r_faddr !== e) begin miscompares++; $display("FAIL lw_fetch_addr: got %h want %h", r_faddr, e); end
        vectors++; if (r_dreq !== 4 || r_we !== 1'b0) begin miscompares++; $display("FAIL lw_dmem_req: got %0d cycles we %b want 4 cycles we 0", r_dreq, r_we); end
        vectors++; if (r_wr !== 1 || r_m2r !== 2'b01) begin miscompares++; $display("FAIL lw_writeback: got wr %0d m2r %b want 1 and 01", r_wr, r_m2r); end
        vectors++; if (r_cycles !== 8 || r_lb !== 1'b0) begin miscompares++; $display("FAIL lw_latency: got %0d lb %b want 8 lb 0", r_cycles, r_lb); end
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b100000, 5'd1, 5'd6, 16'hFFFF), 0, 0, 0);
        exp_addr.push_back(32'h3014);
        vectors++; if (r_faddr !== e || r_cycles !== 5) begin miscompares++; $display("FAIL lb_fetch_latency: got %h/%0d want %h/5", r_faddr, r_cycles, e); end
        vectors++; if (r_lb !== 1'b1 || r_dreq !== 1) begin miscompares++; $display("FAIL lb_qualifier: got lb %b req %0d want 1 and 1", r_lb, r_dreq); end
    endtask

    task automatic test_store();
        logic [31:0] e;
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b101011, 5'd1, 5'd2, 16'h0004), 0, 1, 0);
        exp_addr.push_back(32'h3018);
        vectors++; if (r_faddr !== e || r_cycles !== 5) begin miscompares++; $display("FAIL sw_fetch_latency: got %h/%0d want %h/5", r_faddr, r_cycles, e); end
        vectors++; if (r_we !== 1'b1 || r_dreq !== 2 || r_wr !== 0) begin miscompares++; $display("FAIL sw_bus: got we %b req %0d wr %0d want 1 2 0", r_we, r_dreq, r_wr); end
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b101000, 5'd1, 5'd2, 16'h0005), 0, 0, 0);
        exp_addr.push_back(32'h301C);
        vectors++; if (r_faddr !== e || r_cycles !== 4) begin miscompares++; $display("FAIL sb_fetch_latency: got %h/%0d want %h/4", r_faddr, r_cycles, e); end
        vectors++; if (r_sb !== 1'b1 || r_we !== 1'b1) begin miscompares++; $display("FAIL sb_qualifier: got sb %b we %b want 1 1", r_sb, r_we); end
    endtask

    task automatic test_branch();
        logic [31:0] e;
        jr_target = 32'h3008;
        e = exp_addr.pop_front();
        run_instr(enc_r(5'd7, 5'd0, 5'd0, 6'b001000), 0, 0, 0);
        exp_addr.push_back(32'h3008);
        vectors++; if (r_faddr !== e || r_cycles !== 3) begin miscompares++; $display("FAIL jr_fetch_latency: got %h/%0d want %h/3", r_faddr, r_cycles, e); end
        alu_zero = 1'b1;
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b000100, 5'd1, 5'd2, 16'hFFFF), 0, 0, 0);
        exp_addr.push_back(32'h3008);
        vectors++; if (r_faddr !== e || r_cycles !== 3) begin miscompares++; $display("FAIL jr_target_fetch: got %h/%0d want %h/3", r_faddr, r_cycles, e); end
        alu_zero = 1'b0;
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b000100, 5'd1, 5'd2, 16'hFFFF), 0, 0, 0);
        exp_addr.push_back(32'h300C);
        vectors++; if (r_faddr !== e) begin miscompares++; $display("FAIL beq_taken_fetch: got %h want %h", r_faddr, e); end
        alu_gez = 1'b1;
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b000001, 5'd3, 5'd1, 16'h0004), 0, 0, 0);
        exp_addr.push_back(32'h3020);
        vectors++; if (r_faddr !== e || r_wr !== 0) begin miscompares++; $display("FAIL beq_not_taken_fetch: got %h wr %0d want %h wr 0", r_faddr, r_wr, e); end
        alu_gez = 1'b0;
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b000001, 5'd3, 5'd1, 16'h0004), 0, 0, 0);
        exp_addr.push_back(32'h3024);
        vectors++; if (r_faddr !== e) begin miscompares++; $display("FAIL bgez_taken_fetch: got %h want %h", r_faddr, e); end
    endtask

    task automatic test_jump();
        logic [31:0] e;
        logic [31:0] jal_w;
        e = exp_addr.pop_front();
        run_instr({6'b000010, 26'h0000C00}, 0, 0, 0);
        exp_addr.push_back(32'h3000);
        vectors++; if (r_faddr !== e || r_cycles !== 2) begin miscompares++; $display("FAIL bgez_nt_then_j: got %h/%0d want %h/2", r_faddr, r_cycles, e); end
        jal_w = {6'b000011, 26'h0000C10};
        e = exp_addr.pop_front();
        run_instr(jal_w, 0, 0, 1);
        exp_addr.push_back(32'h3040);
        vectors++; if (r_faddr !== e || r_cycles !== 3) begin miscompares++; $display("FAIL j_target_jal_latency: got %h/%0d want %h/3", r_faddr, r_cycles, e); end
        vectors++; if ({r_rdst, r_m2r} !== 4'b1010 || r_pcwr !== 32'h3004 || r_wr !== 1) begin
            miscompares++; $display("FAIL jal_link: got dst %b m2r %b pc %h wr %0d want 10 10 00003004 1", r_rdst, r_m2r, r_pcwr, r_wr); end
        vectors++; if (instr !== jal_w || r_dreq !== 0) begin miscompares++; $display("FAIL spurious_ack: got instr %h dreq %0d want %h 0", instr, r_dreq, jal_w); end
    endtask

    task automatic test_nop_illegal();
        logic [31:0] e;
        e = exp_addr.pop_front();
        run_instr(32'h0000_0000, 0, 0, 0);
        exp_addr.push_back(32'h3044);
        vectors++; if (r_faddr !== e || r_cycles !== 3 || r_wr !== 0) begin miscompares++; $display("FAIL jal_target_nop: got %h/%0d wr %0d want %h/3 wr 0", r_faddr, r_cycles, r_wr, e); end
        e = exp_addr.pop_front();
        run_instr({6'b111111, 26'h0}, 0, 0, 0);
        vectors++; if (r_faddr !== e) begin miscompares++; $display("FAIL illegal_fetch_addr: got %h want %h", r_faddr, e); end
`ifdef ILLEGAL_TRAP_EN
        vectors++; if (state !== 3'd5 || bus_err !== 1'b0 || r_cycles !== 2) begin
            miscompares++; $display("FAIL illegal_trap: got state %0d err %b cycles %0d want 5 0 2", state, bus_err, r_cycles); end
        reset = 1'b1; tick(); reset = 1'b0;
        exp_addr.delete();
        exp_addr.push_back(32'h3000);
`else
        vectors++; if (r_cycles !== 3 || r_wr !== 0 || r_dreq !== 0 || pc !== 32'h3048) begin
            miscompares++; $display("FAIL illegal_as_nop: got cycles %0d wr %0d dreq %0d pc %h want 3 0 0 00003048", r_cycles, r_wr, r_dreq, pc); end
        exp_addr.push_back(32'h3048);
`endif
    endtask

    task automatic test_timeout();
        logic [31:0] e;
        e = exp_addr.pop_front();
        run_instr(32'h0, 1000, 0, 0);
        vectors++; if (r_faddr !== e || r_stable !== 1'b1) begin miscompares++; $display("FAIL timeout_fetch_addr: got %h stable %b want %h stable 1", r_faddr, r_stable, e); end
        vectors++; if (r_cycles !== 16 || state !== 3'd5 || bus_err !== 1'b1) begin
            miscompares++; $display("FAIL timeout_halt: got cycles %0d state %0d err %b want 16 5 1", r_cycles, state, bus_err); end
        repeat (4) tick();
        vectors++; if (state !== 3'd5 || bus.imem_req !== 1'b0 || bus_err !== 1'b1) begin
            miscompares++; $display("FAIL halt_sticky: got state %0d req %b err %b want 5 0 1", state, bus.imem_req, bus_err); end
        reset = 1'b1; tick(); reset = 1'b0; #1;
        vectors++; if (state !== 3'd0 || bus_err !== 1'b0 || bus.imem_addr !== 32'h3000 || bus.imem_req !== 1'b1) begin
            miscompares++; $display("FAIL halt_reset_exit: got state %0d err %b addr %h req %b want 0 0 00003000 1", state, bus_err, bus.imem_addr, bus.imem_req); end
        exp_addr.delete();
        exp_addr.push_back(32'h3000);
    endtask

    task automatic test_reset_midaccess();
        logic [31:0] e;
        e = exp_addr.pop_front();
        vectors++; if (bus.imem_addr !== e) begin miscompares++; $display("FAIL midreset_fetch_addr: got %h want %h", bus.imem_addr, e); end
        bus.imem_ack = 1'b1; bus.imem_rdata = enc_i(6'b100011, 5'd1, 5'd5, 16'h0000);
        tick(); bus.imem_ack = 1'b0;
        tick(); tick(); tick();
        vectors++; if (state !== 3'd3 || bus.dmem_req !== 1'b1) begin miscompares++; $display("FAIL midreset_in_mem: got state %0d req %b want 3 1", state, bus.dmem_req); end
        reset = 1'b1; tick(); reset = 1'b0; bus.dmem_ack = 1'b1; #1;
        vectors++; if (state !== 3'd0 || bus.dmem_req !== 1'b0 || pc !== 32'h3000) begin
            miscompares++; $display("FAIL midreset_abort: got state %0d dreq %b pc %h want 0 0 00003000", state, bus.dmem_req, pc); end
        tick(); bus.dmem_ack = 1'b0;
        vectors++; if (state !== 3'd0 || reg_wr !== 1'b0) begin miscompares++; $display("FAIL midreset_late_ack: got state %0d wr %b want 0 0", state, reg_wr); end
        exp_addr.push_back(32'h3000);
        e = exp_addr.pop_front();
        run_instr(enc_i(6'b001101, 5'd0, 5'd1, 16'h0001), 0, 0, 0);
        vectors++; if (r_faddr !== e || r_cycles !== 4 || pc !== 32'h3004) begin
            miscompares++; $display("FAIL midreset_resume: got %h/%0d pc %h want %h/4 00003004", r_faddr, r_cycles, pc, e); end
    endtask

    initial begin
        alu_zero = 1'b0; alu_gez = 1'b0; jr_target = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jump();
        test_nop_illegal();
        test_timeout();
        test_reset_midaccess();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
